vectoring_cordic: RTL and testbench

Iterative vectoring-mode CORDIC: accepts a Cartesian vector (x, y) and returns its magnitude and angle, driving y to zero one micro-rotation per clock. It is the inverse direction of the team's pipelined rotational CORDIC (angle-in, vector-out). Together they provide polar-to-Cartesian and Cartesian-to-polar conversion in the same fixed-point formats. Valid/ready handshakes sit on both sides so it can be placed between streaming stages.

---
 rtl/vectoring_cordic.sv | 184 ++++++++++++++++++
 tb/tb_vectoring_cordic.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vectoring_cordic.sv
// Iterative vectoring-mode CORDIC: (x, y) -> (magnitude, theta), one micro-rotation per clock.
// Optional gain compensation stage enabled by defining CORDIC_VEC_GAIN_COMP_EN.
module vectoring_cordic #(
  parameter int ITER = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [15:0] x,
  input  logic signed [15:0] y,
  output logic               out_valid,
  input  logic               out_ready,
  output logic        [16:0] magnitude,
  output logic signed [15:0] theta
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_COMP = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [3:0] LAST_STEP = 4'(ITER - 1);

  function automatic logic signed [15:0] atan_lut(input logic [3:0] idx);
    case (idx)
      4'd0:    atan_lut = 16'sd6434;
      4'd1:    atan_lut = 16'sd3798;
      4'd2:    atan_lut = 16'sd2007;
      4'd3:    atan_lut = 16'sd1019;
      4'd4:    atan_lut = 16'sd511;
      4'd5:    atan_lut = 16'sd256;
      4'd6:    atan_lut = 16'sd128;
      4'd7:    atan_lut = 16'sd64;
      4'd8:    atan_lut = 16'sd32;
      4'd9:    atan_lut = 16'sd16;
      4'd10:   atan_lut = 16'sd8;
      4'd11:   atan_lut = 16'sd4;
      4'd12:   atan_lut = 16'sd2;
      4'd13:   atan_lut = 16'sd1;
      default: atan_lut = 16'sd0;
    endcase
  endfunction

  state_e             state_q, state_d;
  logic signed [17:0] xr_q, xr_d, yr_q, yr_d;
  logic signed [15:0] z_q, z_d;
  logic        [3:0]  i_q, i_d;
  logic               zero_q, zero_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic        [16:0] mag_q, mag_d;
  logic signed [15:0] theta_q, theta_d;

  logic signed [17:0] x_ext_s, y_ext_s, xs_s, ys_s, step_x_s, step_y_s;
  logic signed [15:0] step_z_s;

  assign x_ext_s = {{2{x[15]}}, x};
  assign y_ext_s = {{2{y[15]}}, y};
  assign xs_s    = xr_q >>> i_q;
  assign ys_s    = yr_q >>> i_q;

  // Micro-rotation direction follows the sign of yr; both updates use pre-step values.
  assign step_x_s = yr_q[17] ? (xr_q - ys_s) : (xr_q + ys_s);
  assign step_y_s = yr_q[17] ? (yr_q + xs_s) : (yr_q - xs_s);
  assign step_z_s = yr_q[17] ? (z_q - atan_lut(i_q)) : (z_q + atan_lut(i_q));

`ifdef CORDIC_VEC_GAIN_COMP_EN
  logic [31:0] prod_s;
  assign prod_s = ({15'd0, xr_q[16:0]} * 32'd19898) + 32'd16384;
`endif

  always_comb begin
    state_d     = state_q;
    xr_d        = xr_q;
    yr_d        = yr_q;
    z_d         = z_q;
    i_d         = i_q;
    zero_d      = zero_q;
    in_ready_d  = 1'b0;
    out_valid_d = out_valid_q;
    mag_d       = mag_q;
    theta_d     = theta_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          // Quadrant pre-rotation brings the vector into the right half-plane.
          if (!x[15]) begin
            xr_d = x_ext_s;
            yr_d = y_ext_s;
            z_d  = 16'sd0;
          end else if (!y[15]) begin
            xr_d = y_ext_s;
            yr_d = -x_ext_s;
            z_d  = 16'sd12868;
          end else begin
            xr_d = -y_ext_s;
            yr_d = x_ext_s;
            z_d  = -16'sd12868;
          end
          zero_d  = (x == 16'sd0) && (y == 16'sd0);
          i_d     = 4'd0;
          state_d = ST_ITER;
        end else begin
          in_ready_d = 1'b1;
        end
      end
      ST_ITER: begin
        xr_d = step_x_s;
        yr_d = step_y_s;
        z_d  = step_z_s;
        i_d  = i_q + 4'd1;
        if (i_q == LAST_STEP) begin
`ifdef CORDIC_VEC_GAIN_COMP_EN
          state_d = ST_COMP;
`else
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
          mag_d       = step_x_s[16:0];
          theta_d     = zero_q ? 16'sd0 : step_z_s;
`endif
        end else begin
          state_d = ST_ITER;
        end
      end
`ifdef CORDIC_VEC_GAIN_COMP_EN
      ST_COMP: begin
        state_d     = ST_DONE;
        out_valid_d = 1'b1;
        mag_d       = 17'(prod_s >> 15);
        theta_d     = zero_q ? 16'sd0 : z_q;
      end
`endif
      ST_DONE: begin
        if (out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      xr_q        <= 18'sd0;
      yr_q        <= 18'sd0;
      z_q         <= 16'sd0;
      i_q         <= 4'd0;
      zero_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      mag_q       <= 17'd0;
      theta_q     <= 16'sd0;
    end else begin
      state_q     <= state_d;
      xr_q        <= xr_d;
      yr_q        <= yr_d;
      z_q         <= z_d;
      i_q         <= i_d;
      zero_q      <= zero_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      mag_q       <= mag_d;
      theta_q     <= theta_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign magnitude = mag_q;
  assign theta     = theta_q;

endmodule

// File: tb/tb_vectoring_cordic.sv
// Self-checking bench for vectoring_cordic: real-math reference model feeding a result scoreboard.
module tb_vectoring_cordic;
  localparam int ITER = 16;
`ifdef CORDIC_VEC_GAIN_COMP_EN
  localparam int  LAT  = ITER + 1;
  localparam real GAIN = 1.0;
`else
  localparam int  LAT  = ITER;
  localparam real GAIN = 1.646760258;
`endif
  localparam int MAG_TOL = 8;
  localparam int TH_TOL  = 4;

  typedef struct {
    int mag;
    int th;
  } exp_t;

  logic               clk;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] x_in;
  logic signed [15:0] y_in;
  logic               out_valid;
  logic               out_ready;
  logic        [16:0] magnitude;
  logic signed [15:0] theta;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  vectoring_cordic #(.ITER(ITER)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x        (x_in),
    .y        (y_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .magnitude(magnitude),
    .theta    (theta)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input int xv, input int yv);
    exp_t e;
    real  r;
    r     = $sqrt(real'(xv) * real'(xv) + real'(yv) * real'(yv)) * GAIN;
    e.mag = int'(r);
    e.th  = int'($atan2(real'(yv), real'(xv)) * 8192.0);
    return e;
  endfunction

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic drive(input int xv, input int yv);
    x_in     = 16'(xv);
    y_in     = 16'(yv);
    in_valid = 1'b1;
    sb_q.push_back(model(xv, yv));
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid && lat < 200);
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1; x_in = 16'sd0; y_in = 16'sd0;
    repeat (2) @(negedge clk);
    checks += 4;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    if (magnitude !== 17'd0) begin errors++; $display("FAIL reset_mag: got %0d want 0", magnitude); end
    if (theta !== 16'sd0) begin errors++; $display("FAIL reset_theta: got %0d want 0", theta); end
    reset = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL release_in_ready_low: got %b want 0", in_ready); end
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready_high: got %b want 1", in_ready); end
  endtask

  task automatic test_vectors();
    int vx[6] = '{16384, 0, -16384, 0, -32768, -12000};
    int vy[6] = '{0, 16384, -16384, 0, 0, 7000};
    for (int k = 0; k < 6; k++) begin
      bit   ok;
      int   lat;
      exp_t e;
      wait_ready(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL vec%0d_ready: in_ready never rose", k); end
      drive(vx[k], vy[k]);
      @(posedge clk);
      #1 in_valid = 1'b0;
      wait_out(lat);
      checks += 3;
      if (lat !== LAT) begin errors++; $display("FAIL vec%0d_latency: got %0d want %0d", k, lat, LAT); end
      e = sb_q.pop_front();
      if (int'(magnitude) > e.mag + MAG_TOL || int'(magnitude) < e.mag - MAG_TOL) begin
        errors++; $display("FAIL vec%0d_mag: got %0d want %0d", k, magnitude, e.mag);
      end
      if (int'(theta) > e.th + TH_TOL || int'(theta) < e.th - TH_TOL) begin
        errors++; $display("FAIL vec%0d_theta: got %0d want %0d", k, theta, e.th);
      end
    end
  endtask

  task automatic test_hold();
    bit   ok;
    int   lat;
    exp_t e;
    wait_ready(ok);
    drive(3000, -4000);
    out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_out(lat);
    e = sb_q.pop_front();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = c[0];
      x_in     = 16'($urandom);
      y_in     = 16'($urandom);
      @(posedge clk);
      #1;
      checks += 4;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL hold%0d_out_valid: got %b want 1", c, out_valid); end
      if (in_ready !== 1'b0) begin errors++; $display("FAIL hold%0d_in_ready: got %b want 0", c, in_ready); end
      if (int'(magnitude) > e.mag + MAG_TOL || int'(magnitude) < e.mag - MAG_TOL) begin
        errors++; $display("FAIL hold%0d_mag: got %0d want %0d", c, magnitude, e.mag);
      end
      if (int'(theta) > e.th + TH_TOL || int'(theta) < e.th - TH_TOL) begin
        errors++; $display("FAIL hold%0d_theta: got %0d want %0d", c, theta, e.th);
      end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_release_out_valid: got %b want 0", out_valid); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL hold_release_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_reset_abort();
    bit   ok;
    int   lat;
    exp_t e;
    wait_ready(ok);
    drive(1234, 5678);
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    sb_q.delete();
    checks += 4;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_out_valid: got %b want 0", out_valid); end
    if (in_ready !== 1'b0) begin errors++; $display("FAIL abort_in_ready: got %b want 0", in_ready); end
    if (magnitude !== 17'd0) begin errors++; $display("FAIL abort_mag: got %0d want 0", magnitude); end
    if (theta !== 16'sd0) begin errors++; $display("FAIL abort_theta: got %0d want 0", theta); end
    @(negedge clk);
    reset = 1'b1;
    wait_ready(ok);
    drive(10000, 10000);
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_out(lat);
    e = sb_q.pop_front();
    checks += 3;
    if (lat !== LAT) begin errors++; $display("FAIL abort_latency: got %0d want %0d", lat, LAT); end
    if (int'(magnitude) > e.mag + MAG_TOL || int'(magnitude) < e.mag - MAG_TOL) begin
      errors++; $display("FAIL abort_mag_after: got %0d want %0d", magnitude, e.mag);
    end
    if (int'(theta) > e.th + TH_TOL || int'(theta) < e.th - TH_TOL) begin
      errors++; $display("FAIL abort_theta_after: got %0d want %0d", theta, e.th);
    end
  endtask

  task automatic test_back_to_back();
    int  vx[3] = '{20000, -7000, 100};
    int  vy[3] = '{-5000, 9000, -30000};
    int  acc[3] = '{0, 0, 0};
    int  sent = 0, nacc = 0, outs = 0;
    bit  pend = 1'b0;
    bit  ok;
    wait_ready(ok);
    drive(vx[0], vy[0]);
    sent = 1;
    for (int c = 0; c < 300; c++) begin
      if (out_valid && sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        checks += 2;
        if (int'(magnitude) > e.mag + MAG_TOL || int'(magnitude) < e.mag - MAG_TOL) begin
          errors++; $display("FAIL b2b%0d_mag: got %0d want %0d", outs, magnitude, e.mag);
        end
        if (int'(theta) > e.th + TH_TOL || int'(theta) < e.th - TH_TOL) begin
          errors++; $display("FAIL b2b%0d_theta: got %0d want %0d", outs, theta, e.th);
        end
        outs++;
      end
      if (pend) begin
        if (sent < 3) begin
          drive(vx[sent], vy[sent]);
          sent++;
        end else begin
          in_valid = 1'b0;
        end
        pend = 1'b0;
      end
      if (in_valid && in_ready && nacc < 3) begin
        acc[nacc] = c;
        nacc++;
        pend = 1'b1;
      end
      if (outs == 3) break;
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks += 3;
    if (outs !== 3) begin errors++; $display("FAIL b2b_outputs: got %0d want 3", outs); end
    if (acc[1] - acc[0] !== LAT + 2) begin
      errors++; $display("FAIL b2b_interval1: got %0d want %0d", acc[1] - acc[0], LAT + 2);
    end
    if (acc[2] - acc[1] !== LAT + 2) begin
      errors++; $display("FAIL b2b_interval2: got %0d want %0d", acc[2] - acc[1], LAT + 2);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_hold();
    test_reset_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
